// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_JUMP,
        S_WB,
        S_PC_UPD,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [3:0] PATH_ALU_MAX = 4'd4;
    localparam logic [3:0] PATH_J       = 4'd5;
    localparam logic [3:0] PATH_JAL     = 4'd6;
    localparam logic [3:0] PATH_BR      = 4'd7;
    localparam logic [3:0] PATH_JR      = 4'd8;
    localparam logic [3:0] PATH_LD      = 4'd9;
    localparam logic [3:0] PATH_ST      = 4'd10;
    localparam logic [3:0] PATH_HALT    = 4'd15;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_JUMP = 2'd1;
    localparam logic [1:0] PC_SRC_BR   = 2'd2;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_ILLEGAL = 2'd2;

    function automatic logic [1:0] pc_src_sel(
        input logic [3:0] path,
        input logic       taken
    );
        if (path == PATH_J || path == PATH_JAL || path == PATH_JR)
            return PC_SRC_JUMP;
        if (path == PATH_BR && taken)
            return PC_SRC_BR;
        return PC_SRC_SEQ;
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Enable/done handshake bundle between sequencer and datapath units.
interface mc_sequencer_if;

    logic en_fetch;
    logic en_alu;
    logic en_mem;
    logic en_jump;
    logic en_wb;
    logic fetch_done;
    logic alu_done;
    logic mem_done;
    logic jump_done;
    logic wb_done;

    modport master (
        output en_fetch, en_alu, en_mem, en_jump, en_wb,
        input  fetch_done, alu_done, mem_done, jump_done, wb_done
    );

    modport slave (
        input  en_fetch, en_alu, en_mem, en_jump, en_wb,
        output fetch_done, alu_done, mem_done, jump_done, wb_done
    );

endinterface

// File: rtl/stage_watchdog.sv
// Per-state cycle counter: first-cycle flag and terminal-count flag.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic first,
    output logic tc
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // Saturates so terminal states can sit here forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != LAST)
            cnt <= cnt + W'(1);
    end

    assign first = (cnt == '0);
    assign tc    = (cnt == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: unit enables, PC commit, retire count.
module mc_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_sequencer_if.master   bus,
    input  logic             run,
    input  logic [3:0]       path_index,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code
);

    state_t     state, state_n;
    logic [3:0] path_q;
    logic [1:0] code_n;
    logic       unit_done, handshaked, accept;
    logic       first, tc;

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_n != state),
        .first (first),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        unit_done  = 1'b0;
        handshaked = 1'b1;
        unique case (state)
            S_FETCH: unit_done = bus.fetch_done;
            S_EXEC:  unit_done = bus.alu_done;
            S_MEM:   unit_done = bus.mem_done;
            S_JUMP:  unit_done = bus.jump_done;
            S_WB:    unit_done = bus.wb_done;
            default: handshaked = 1'b0;
        endcase
    end

    // A done left over from the unit's previous use is masked in cycle one.
    assign accept = handshaked && unit_done && !first;

    always_comb begin
        state_n = state;
        code_n  = FC_NONE;
        unique case (state)
            S_IDLE:
                if (run) state_n = S_FETCH;
            S_FETCH:
                if (accept) state_n = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (path_index <= PATH_ALU_MAX),
                    (path_index == PATH_BR),
                    (path_index == PATH_LD),
                    (path_index == PATH_ST):
                        state_n = S_EXEC;
                    (path_index == PATH_J),
                    (path_index == PATH_JAL),
                    (path_index == PATH_JR):
                        state_n = S_JUMP;
                    (path_index == PATH_HALT):
                        state_n = S_HALT;
                    default: begin
                        state_n = S_FAULT;
                        code_n  = FC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC:
                if (accept) begin
                    if (path_q == PATH_LD || path_q == PATH_ST)
                        state_n = S_MEM;
                    else if (path_q == PATH_BR)
                        state_n = S_PC_UPD;
                    else
                        state_n = S_WB;
                end
            S_MEM:
                if (accept)
                    state_n = (path_q == PATH_LD) ? S_WB : S_PC_UPD;
            S_JUMP:
                if (accept)
                    state_n = (path_q == PATH_JAL) ? S_WB : S_PC_UPD;
            S_WB:
                if (accept) state_n = S_PC_UPD;
            S_PC_UPD:
                state_n = run ? S_FETCH : S_IDLE;
            default:
                state_n = state;
        endcase
        if (handshaked && !accept && tc) begin
            state_n = S_FAULT;
            code_n  = FC_TIMEOUT;
        end
    end

    always_comb begin
        bus.en_fetch = 1'b0;
        bus.en_alu   = 1'b0;
        bus.en_mem   = 1'b0;
        bus.en_jump  = 1'b0;
        bus.en_wb    = 1'b0;
        pc_we        = 1'b0;
        unique case (state)
            S_FETCH:  bus.en_fetch = 1'b1;
            S_EXEC:   bus.en_alu   = 1'b1;
            S_MEM:    bus.en_mem   = 1'b1;
            S_JUMP:   bus.en_jump  = 1'b1;
            S_WB:     bus.en_wb    = 1'b1;
            S_PC_UPD: pc_we        = 1'b1;
            default:  ;
        endcase
    end

    assign halted = (state == S_HALT);
    assign fault  = (state == S_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            path_q     <= '0;
            pc_src     <= PC_SRC_SEQ;
            retired    <= '0;
            fault_code <= FC_NONE;
        end else begin
            if (state == S_DECODE)
                path_q <= path_index;
            if (state_n == S_PC_UPD && state != S_PC_UPD)
                pc_src <= pc_src_sel(path_q, branch_taken);
            if (state == S_PC_UPD)
                retired <= retired + CNT_W'(1);
            if (state_n == S_FAULT && state != S_FAULT)
                fault_code <= code_n;
        end
    end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the MIPS core. It walks each instruction through fetch, decode, execute, memory, jump, write-back and PC-update phases, and raises one enable at a time to the matching datapath unit (fetch, ALU, memory, jump unit, register write-back). Each unit answers with a done handshake. The sequencer then commits the PC through a one-cycle write strobe and a source select. It also counts retired instructions and traps hangs, illegal paths and halts.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles any unit enable may stay high without its done before the sequencer faults (≥2).
- CNT_W, 32: width of the retired-instruction counter.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  high lets the sequencer leave IDLE and keep issuing instructions.
- path_index  in  4  decoded instruction class, sampled in DECODE.
- branch_taken  in  1  ALU compare result, sampled on leaving EXEC for path 7.
- fetch_done, alu_done, mem_done, jump_done, wb_done  in  1 each  unit completion flags.
- en_fetch, en_alu, en_mem, en_jump, en_wb  out  1 each  unit enables; at most one is high at a time.
- pc_we  out  1  one-cycle PC write strobe.
- pc_src  out  2  PC source: 0 = pc+1, 1 = jump unit output, 2 = branch target.
- retired  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- halted  out  1  sticky; set after a halt instruction.
- fault  out  1  sticky; set on timeout or illegal path.
- fault_code  out  2  0 = none, 1 = timeout, 2 = illegal path.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, JUMP, WB, PC_UPD, HALT, FAULT.
- IDLE → FETCH when run = 1.
- FETCH → DECODE on an accepted fetch_done.
- DECODE lasts exactly 1 cycle, has no handshake, and latches path_index.
- Routing after DECODE, by path_index:
  - 0–4 (ALU): EXEC → WB → PC_UPD, with src 0.
  - 5 (J): JUMP → PC_UPD, with src 1.
  - 6 (JAL): JUMP → WB → PC_UPD, with src 1.
  - 7 (branch): EXEC → PC_UPD, with src 2 if branch_taken else 0.
  - 8 (JR): JUMP → PC_UPD, with src 1.
  - 9 (load): EXEC → MEM → WB → PC_UPD, with src 0.
  - 10 (store): EXEC → MEM → PC_UPD, with src 0.
  - 15 (halt): → HALT.
  - 11–14: → FAULT, with code 2.
- Unit handshake:
  - The state's enable is high for the whole state.
  - done is ignored in the first cycle of the state. Units may still hold a stale done from the previous use.
  - done is accepted from the second cycle on. On acceptance the sequencer moves to the next state and the enable drops in that same transition.
- PC_UPD lasts 1 cycle: pc_we = 1, pc_src valid, retired increments. Next state is FETCH if run = 1, else IDLE.
- Watchdog:
  - A per-state cycle counter clears on every state entry.
  - If it reaches TIMEOUT_CYCLES with no accepted done, the sequencer goes to FAULT with code 1.
- HALT and FAULT are terminal: all enables 0, pc_we 0, exit only through rst_n.
- run falling mid-instruction does not abort. The current instruction completes, and the sequencer stops in IDLE after PC_UPD.

## Timing
- Reset (asynchronous assert) values: state IDLE; all enables 0; pc_we 0; pc_src 0; retired 0; halted 0; fault 0; fault_code 0; watchdog 0.
- Reset deassertion: first state change on the first clk edge with rst_n high and run = 1.
- Each handshaked state lasts at least 2 cycles.
- Minimum cycles per instruction (FETCH through PC_UPD):
  - ALU: 8
  - J, JR: 6
  - JAL: 8
  - branch: 6
  - load: 10
  - store: 8
- Timeout: enable high for exactly TIMEOUT_CYCLES cycles; fault asserts on the next edge.
- If done is accepted on the same edge the timeout would fire, done wins.
- pc_src is held stable from PC_UPD until the next PC_UPD. It is 0 after reset.
- Reset mid-instruction: all outputs return to their reset values immediately, and no pc_we is issued.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - path_index constants (PATH_J = 5, PATH_JAL = 6, PATH_BR = 7, PATH_JR = 8, PATH_LD = 9, PATH_ST = 10, PATH_HALT = 15);
  - pc_src constants;
  - fault_code constants.
- One sub-module, stage_watchdog: a cycle counter with clear-on-state-change and a terminal-count flag, parameterised by TIMEOUT_CYCLES.

## Test plan
- ALU instruction (path 2), every unit answers done on the second enable cycle → exactly 8 cycles from leaving IDLE to pc_we; pc_src = 0; retired = 1.
- JR (path 8) with jump_done already high on entry to JUMP → done ignored in the first cycle; en_jump high for exactly 2 cycles; pc_src = 1.
- Branch (path 7), branch_taken = 1, then the same branch with branch_taken = 0 → pc_src 2 then 0; retired = 2.
- Load whose mem_done never asserts, TIMEOUT_CYCLES = 16 → en_mem high for 16 cycles, then fault = 1, fault_code = 1, all enables 0, held until rst_n.
- path_index = 12 → FAULT with code 2. Separately, path_index = 15 → halted = 1 and no further enables.
- rst_n pulled low during MEM of a store → all outputs at reset values within the same cycle; after release with run = 1, FETCH resumes; retired counts from 0.
